trap_ctrl: RTL and testbench

- Parametrised machine-mode trap unit for the NPC core: prioritises synchronous exceptions and masked interrupts, captures trap context at IDU handshake, and commits mepc/mcause/mtval/mstatus on LSU handshake.
- Generates a one-cycle PC redirect (mtvec or mepc) and stalls upstream while a trap is in flight.
- Handles ecall, ebreak, illegal instruction, load/store misaligned, mret, and IRQ_NUM interrupt lines.

---
 rtl/trap_ctrl_if.sv | 52 +++++
 rtl/trap_ctrl.sv | 113 +++++++++++
 tb/tb_trap_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - decode/commit/CSR signal bundle between the pipeline and trap_ctrl
interface trap_ctrl_if #(
    parameter int XLEN    = 32,
    parameter int IRQ_NUM = 3
);
    logic               i_idu_valid;
    logic               i_lsu_valid;
    logic [XLEN-1:0]    i_pc;
    logic [31:0]        i_inst;
    logic [XLEN-1:0]    i_badaddr;
    logic               i_ecall;
    logic               i_ebreak;
    logic               i_illegal;
    logic               i_ld_misalign;
    logic               i_st_misalign;
    logic               i_mret;
    logic [IRQ_NUM-1:0] i_irq;
    logic [IRQ_NUM-1:0] i_mie;
    logic [XLEN-1:0]    i_mstatus;
    logic [XLEN-1:0]    i_mtvec;
    logic [XLEN-1:0]    i_mepc;

    logic               o_mepc_wen;
    logic               o_mcause_wen;
    logic               o_mtval_wen;
    logic               o_mstatus_wen;
    logic [XLEN-1:0]    o_mepc_wdata;
    logic [XLEN-1:0]    o_mcause_wdata;
    logic [XLEN-1:0]    o_mtval_wdata;
    logic [XLEN-1:0]    o_mstatus_wdata;
    logic               o_redirect;
    logic [XLEN-1:0]    o_redirect_pc;
    logic               o_busy;

    modport master (
        output i_idu_valid, i_lsu_valid, i_pc, i_inst, i_badaddr,
               i_ecall, i_ebreak, i_illegal, i_ld_misalign, i_st_misalign, i_mret,
               i_irq, i_mie, i_mstatus, i_mtvec, i_mepc,
        input  o_mepc_wen, o_mcause_wen, o_mtval_wen, o_mstatus_wen,
               o_mepc_wdata, o_mcause_wdata, o_mtval_wdata, o_mstatus_wdata,
               o_redirect, o_redirect_pc, o_busy
    );

    modport slave (
        input  i_idu_valid, i_lsu_valid, i_pc, i_inst, i_badaddr,
               i_ecall, i_ebreak, i_illegal, i_ld_misalign, i_st_misalign, i_mret,
               i_irq, i_mie, i_mstatus, i_mtvec, i_mepc,
        output o_mepc_wen, o_mcause_wen, o_mtval_wen, o_mstatus_wen,
               o_mepc_wdata, o_mcause_wdata, o_mtval_wdata, o_mstatus_wdata,
               o_redirect, o_redirect_pc, o_busy
    );
endinterface

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap/mret unit; optional TRAP_VECTORED_EN adds vectored interrupt targets
module trap_ctrl #(
    parameter int XLEN    = 32,
    parameter int IRQ_NUM = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    trap_ctrl_if.slave   bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    logic [0:0]         state;
    logic               mret_q;
    logic [XLEN-1:0]    mepc_q, mcause_q, mtval_q, mstatus_q, target_q;

    logic [IRQ_NUM-1:0] irq_pend;
    logic               is_irq, is_exc, is_trap, is_mret;
    logic [XLEN-2:0]    irq_code, exc_code;
    logic [XLEN-1:0]    exc_mtval, base;
    logic [XLEN-1:0]    nxt_mcause, nxt_mtval, nxt_mstatus, nxt_target;
    logic               commit;

    always_comb begin
        irq_pend = bus.i_irq & bus.i_mie & {IRQ_NUM{bus.i_mstatus[3]}};
        is_irq   = |irq_pend;
        irq_code = '0;
        // Ascending scan so the highest pending line overwrites lower ones
        for (int k = 0; k < IRQ_NUM; k++) begin
            if (irq_pend[k]) irq_code = (XLEN-1)'(4*k + 3);
        end

        is_exc    = bus.i_illegal | bus.i_ebreak | bus.i_ecall | bus.i_st_misalign | bus.i_ld_misalign;
        exc_code  = '0;
        exc_mtval = '0;
        if (bus.i_illegal) begin
            exc_code  = (XLEN-1)'(2);
            exc_mtval = XLEN'(bus.i_inst);
        end else if (bus.i_ebreak) begin
            exc_code  = (XLEN-1)'(3);
            exc_mtval = bus.i_pc;
        end else if (bus.i_ecall) begin
            exc_code  = (XLEN-1)'(11);
        end else if (bus.i_st_misalign) begin
            exc_code  = (XLEN-1)'(6);
            exc_mtval = bus.i_badaddr;
        end else if (bus.i_ld_misalign) begin
            exc_code  = (XLEN-1)'(4);
            exc_mtval = bus.i_badaddr;
        end

        is_trap = is_irq | is_exc;
        is_mret = bus.i_mret & ~is_trap;
        base    = {bus.i_mtvec[XLEN-1:2], 2'b00};

        nxt_mcause  = is_irq ? {1'b1, irq_code} : {1'b0, exc_code};
        nxt_mtval   = is_irq ? '0 : exc_mtval;
        nxt_mstatus = bus.i_mstatus;
        nxt_target  = base;
        if (is_mret) begin
            nxt_mstatus[3]     = bus.i_mstatus[7];
            nxt_mstatus[7]     = 1'b1;
            nxt_mstatus[12:11] = 2'b11;
            nxt_target         = bus.i_mepc;
        end else begin
            nxt_mstatus[7]     = bus.i_mstatus[3];
            nxt_mstatus[3]     = 1'b0;
            nxt_mstatus[12:11] = 2'b11;
`ifdef TRAP_VECTORED_EN
            if (is_irq && bus.i_mtvec[1:0] == 2'b01)
                nxt_target = base + {irq_code[XLEN-4:0], 2'b00};
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            mret_q    <= 1'b0;
            mepc_q    <= '0;
            mcause_q  <= '0;
            mtval_q   <= '0;
            mstatus_q <= '0;
            target_q  <= '0;
        end else if (state == IDLE) begin
            if (bus.i_idu_valid && (is_trap || is_mret)) begin
                state     <= PEND;
                mret_q    <= is_mret;
                mepc_q    <= bus.i_pc;
                mcause_q  <= nxt_mcause;
                mtval_q   <= nxt_mtval;
                mstatus_q <= nxt_mstatus;
                target_q  <= nxt_target;
            end
        end else if (bus.i_lsu_valid) begin
            state <= IDLE;
        end
    end

    // Strobes fire only in the retiring cycle; data is held from capture
    assign commit              = (state == PEND) & bus.i_lsu_valid;
    assign bus.o_mepc_wen      = commit & ~mret_q;
    assign bus.o_mcause_wen    = commit & ~mret_q;
    assign bus.o_mtval_wen     = commit & ~mret_q;
    assign bus.o_mstatus_wen   = commit;
    assign bus.o_mepc_wdata    = mepc_q;
    assign bus.o_mcause_wdata  = mcause_q;
    assign bus.o_mtval_wdata   = mtval_q;
    assign bus.o_mstatus_wdata = mstatus_q;
    assign bus.o_redirect      = commit;
    assign bus.o_redirect_pc   = target_q;
    assign bus.o_busy          = (state == PEND);
endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed table-driven bench for trap_ctrl
module tb_trap_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    trap_ctrl_if #(.XLEN(32), .IRQ_NUM(3)) bus ();

    trap_ctrl #(.XLEN(32), .IRQ_NUM(3)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  flags;   // {illegal, ebreak, ecall, st, ld, mret}
        logic [2:0]  irq;
        logic [2:0]  mie;
        logic [31:0] mstatus;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] badaddr;
        logic        ev;
        logic [3:0]  wen;     // {mepc, mcause, mtval, mstatus}
        logic [31:0] mcause;
        logic [31:0] mtval;
        logic [31:0] mst;
        logic [31:0] target;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        bus.i_idu_valid   = 1'b0;
        bus.i_lsu_valid   = 1'b0;
        bus.i_pc          = '0;
        bus.i_inst        = '0;
        bus.i_badaddr     = '0;
        bus.i_ecall       = 1'b0;
        bus.i_ebreak      = 1'b0;
        bus.i_illegal     = 1'b0;
        bus.i_ld_misalign = 1'b0;
        bus.i_st_misalign = 1'b0;
        bus.i_mret        = 1'b0;
        bus.i_irq         = '0;
        bus.i_mie         = '0;
        bus.i_mstatus     = '0;
        bus.i_mtvec       = '0;
        bus.i_mepc        = '0;
    endtask

    task automatic apply(input vec_t v);
        {bus.i_illegal, bus.i_ebreak, bus.i_ecall,
         bus.i_st_misalign, bus.i_ld_misalign, bus.i_mret} = v.flags;
        bus.i_irq     = v.irq;
        bus.i_mie     = v.mie;
        bus.i_mstatus = v.mstatus;
        bus.i_mtvec   = v.mtvec;
        bus.i_mepc    = v.mepc;
        bus.i_pc      = v.pc;
        bus.i_inst    = v.inst;
        bus.i_badaddr = v.badaddr;
    endtask

    function automatic logic [3:0] wens();
        return {bus.o_mepc_wen, bus.o_mcause_wen, bus.o_mtval_wen, bus.o_mstatus_wen};
    endfunction

    initial begin
        logic [31:0] tgt6;
        int busy_cnt;
        checks = 0;
        errors = 0;
`ifdef TRAP_VECTORED_EN
        tgt6 = 32'h8000_011C;
`else
        tgt6 = 32'h8000_0100;
`endif
        vt[0]  = '{6'b001000, 3'b000, 3'b000, 32'h8, 32'h8000_0100, 32'h0, 32'h8000_0010, 32'h0, 32'h0,
                   1'b1, 4'hF, 32'd11, 32'h0, 32'h1880, 32'h8000_0100};
        vt[1]  = '{6'b101000, 3'b000, 3'b000, 32'h0, 32'h8000_0100, 32'h0, 32'h8000_0020, 32'hFFFF_FFFF, 32'h0,
                   1'b1, 4'hF, 32'd2, 32'hFFFF_FFFF, 32'h1800, 32'h8000_0100};
        vt[2]  = '{6'b000010, 3'b000, 3'b000, 32'h8, 32'h8000_0101, 32'h0, 32'h8000_0030, 32'h0, 32'h8000_0003,
                   1'b1, 4'hF, 32'd4, 32'h8000_0003, 32'h1880, 32'h8000_0100};
        vt[3]  = '{6'b000001, 3'b000, 3'b000, 32'h1880, 32'h8000_0100, 32'h8000_0014, 32'h8000_0044, 32'h0, 32'h0,
                   1'b1, 4'h1, 32'h0, 32'h0, 32'h1888, 32'h8000_0014};
        vt[4]  = '{6'b010000, 3'b110, 3'b111, 32'h8, 32'h8000_0100, 32'h0, 32'h8000_0040, 32'h0, 32'h0,
                   1'b1, 4'hF, 32'h8000_000B, 32'h0, 32'h1880, 32'h8000_0100};
        vt[5]  = '{6'b010000, 3'b110, 3'b111, 32'h0, 32'h8000_0100, 32'h0, 32'h8000_0040, 32'h0, 32'h0,
                   1'b1, 4'hF, 32'd3, 32'h8000_0040, 32'h1800, 32'h8000_0100};
        vt[6]  = '{6'b000000, 3'b010, 3'b111, 32'h8, 32'h8000_0101, 32'h0, 32'h8000_0050, 32'h0, 32'h0,
                   1'b1, 4'hF, 32'h8000_0007, 32'h0, 32'h1880, tgt6};
        vt[7]  = '{6'b000110, 3'b000, 3'b000, 32'h8, 32'h8000_0100, 32'h0, 32'h8000_0060, 32'h0, 32'h1001,
                   1'b1, 4'hF, 32'd6, 32'h1001, 32'h1880, 32'h8000_0100};
        vt[8]  = '{6'b000000, 3'b000, 3'b111, 32'h8, 32'h8000_0100, 32'h0, 32'h8000_0064, 32'h0, 32'h0,
                   1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        vt[9]  = '{6'b000000, 3'b111, 3'b000, 32'h8, 32'h8000_0100, 32'h0, 32'h8000_0068, 32'h0, 32'h0,
                   1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        vt[10] = '{6'b001001, 3'b000, 3'b000, 32'h8, 32'h8000_0100, 32'h8000_0099, 32'h8000_0070, 32'h0, 32'h0,
                   1'b1, 4'hF, 32'd11, 32'h0, 32'h1880, 32'h8000_0100};
        vt[11] = '{6'b011100, 3'b000, 3'b000, 32'h0, 32'h8000_0203, 32'h0, 32'h8000_0080, 32'h0, 32'h55,
                   1'b1, 4'hF, 32'd3, 32'h8000_0080, 32'h1800, 32'h8000_0200};
        vt[12] = '{6'b000000, 3'b111, 3'b111, 32'h0, 32'h8000_0100, 32'h0, 32'h8000_0084, 32'h0, 32'h0,
                   1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0};

        clear_in();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(bus.o_busy), 32'h0);
        chk("reset_wen", 32'(wens()), 32'h0);
        chk("reset_redirect", 32'(bus.o_redirect), 32'h0);
        chk("reset_mepc_wdata", bus.o_mepc_wdata, 32'h0);
        chk("reset_redirect_pc", bus.o_redirect_pc, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            apply(vt[i]);
            bus.i_idu_valid = 1'b1;
            @(posedge clk); #1;
            clear_in();
            busy_cnt = 0;
            for (int c = 0; c < 2; c++) begin
                if (bus.o_busy) busy_cnt++;
                chk($sformatf("v%0d_early_wen", i), 32'(wens()), 32'h0);
                @(posedge clk); #1;
            end
            bus.i_lsu_valid = 1'b1;
            #1;
            if (bus.o_busy) busy_cnt++;
            chk($sformatf("v%0d_wen", i), 32'(wens()), 32'(vt[i].wen));
            chk($sformatf("v%0d_redirect", i), 32'(bus.o_redirect), 32'(vt[i].ev));
            if (vt[i].ev) begin
                chk($sformatf("v%0d_redirect_pc", i), bus.o_redirect_pc, vt[i].target);
                chk($sformatf("v%0d_mstatus", i), bus.o_mstatus_wdata, vt[i].mst);
                if (vt[i].wen[3]) begin
                    chk($sformatf("v%0d_mepc", i), bus.o_mepc_wdata, vt[i].pc);
                    chk($sformatf("v%0d_mcause", i), bus.o_mcause_wdata, vt[i].mcause);
                    chk($sformatf("v%0d_mtval", i), bus.o_mtval_wdata, vt[i].mtval);
                end
            end
            @(posedge clk); #1;
            bus.i_lsu_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_busy_after", i), 32'(bus.o_busy), 32'h0);
            chk($sformatf("v%0d_wen_after", i), 32'(wens()), 32'h0);
            chk($sformatf("v%0d_busy_cycles", i), 32'(busy_cnt), vt[i].ev ? 32'd3 : 32'd0);
        end

        // IDU beats during PEND, including the commit cycle, are dropped
        apply(vt[0]);
        bus.i_idu_valid = 1'b1;
        @(posedge clk); #1;
        clear_in();
        bus.i_idu_valid = 1'b1;
        bus.i_illegal   = 1'b1;
        bus.i_pc        = 32'h0000_1234;
        @(posedge clk); #1;
        chk("pend_idu_busy", 32'(bus.o_busy), 32'h1);
        bus.i_lsu_valid = 1'b1;
        #1;
        chk("pend_idu_mcause", bus.o_mcause_wdata, 32'd11);
        chk("pend_idu_mepc", bus.o_mepc_wdata, 32'h8000_0010);
        chk("pend_idu_wen", 32'(wens()), 32'hF);
        @(posedge clk); #1;
        bus.i_lsu_valid = 1'b0;
        bus.i_idu_valid = 1'b0;
        bus.i_illegal   = 1'b0;
        #1;
        chk("dropped_beat_busy", 32'(bus.o_busy), 32'h0);
        @(posedge clk); #1;
        chk("dropped_beat_busy2", 32'(bus.o_busy), 32'h0);

        // Reset mid-PEND aborts the trap even with LSU handshake present
        apply(vt[4]);
        bus.i_idu_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_idu_valid = 1'b0;
        chk("rst_pend_busy_before", 32'(bus.o_busy), 32'h1);
        bus.i_lsu_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_pend_busy", 32'(bus.o_busy), 32'h0);
        chk("rst_pend_wen", 32'(wens()), 32'h0);
        chk("rst_pend_redirect", 32'(bus.o_redirect), 32'h0);
        chk("rst_pend_mcause", bus.o_mcause_wdata, 32'h0);
        @(negedge clk);
        bus.i_lsu_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_busy", 32'(bus.o_busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
